// File: rtl/mips_exec_ctrl_pkg.sv
// mips_exec_ctrl_pkg
//   Shared definitions for the MIPS execution controller: the controller
//   state encoding (also driven out on the mode port) and its width.
//   Ports: none (package).
package mips_exec_ctrl_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        S_RUN  = 2'd0,
        S_HALT = 2'd1,
        S_STEP = 2'd2
    } exec_state_t;

endpackage

// File: rtl/mips_exec_ctrl_btn_edge_sync.sv
// btn_edge_sync
//   Brings an asynchronous push-button into the clock domain through a
//   STAGES-deep flop chain and emits a registered one-cycle pulse on each
//   rising edge. The pulse appears STAGES+1 clock edges after the first edge
//   that samples the button high.
//   Ports:
//     clock  in   system clock
//     reset  in   synchronous, active-high; clears the chain (no pulse)
//     btn    in   asynchronous button level
//     pulse  out  one-cycle rising-edge pulse
module btn_edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    logic [STAGES-1:0] sync_p0;
    logic              last_p1;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_p0 <= '0;
            last_p1 <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            // stage 0: metastability chain
            sync_p0 <= {sync_p0[STAGES-2:0], btn};
            // stage 1: edge detect against the previous synchronized level
            last_p1 <= sync_p0[STAGES-1];
            pulse   <= sync_p0[STAGES-1] & ~last_p1;
        end
    end

endmodule

// File: rtl/mips_exec_ctrl.sv
// mips_exec_ctrl
//   Execution controller for the MIPS core. Produces a synchronous enable
//   (core_en) for PC, register file and memory writes; the clock itself is
//   never gated. Modes: free run, N-instruction step burst, halt. Supports
//   PC breakpoints and an external level halt request.
//   Optional build macro MIPS_EXEC_CTRL_PERF_EN adds cycle_cnt/retired_cnt.
//   Ports:
//     clock, reset          system clock, synchronous active-high reset
//     change, step          async buttons (run/halt toggle, start step burst)
//     step_count            instructions per burst (0 behaves as 1)
//     halt_req              level halt request
//     pc                    current PC
//     bp_we/bp_idx/bp_addr/bp_valid   breakpoint slot write port
//     core_en               enable for this cycle
//     halted, mode          controller state
//     bp_hit, bp_hit_idx    sticky breakpoint-halt flag and slot
//     cycle_cnt, retired_cnt  (PERF build only) cycles / enabled cycles
module mips_exec_ctrl
    import mips_exec_ctrl_pkg::*;
#(
    parameter  int ADDR_W      = 32,
    parameter  int NUM_BP      = 4,
    parameter  int CNT_W       = 8,
    parameter  int SYNC_STAGES = 2,
    localparam int IDX_W       = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              change,
    input  logic              step,
    input  logic [CNT_W-1:0]  step_count,
    input  logic              halt_req,
    input  logic [ADDR_W-1:0] pc,
    input  logic              bp_we,
    input  logic [IDX_W-1:0]  bp_idx,
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic              bp_valid,
    output logic              core_en,
    output logic              halted,
    output logic [MODE_W-1:0] mode,
    output logic              bp_hit,
    output logic [IDX_W-1:0]  bp_hit_idx
`ifdef MIPS_EXEC_CTRL_PERF_EN
    ,
    output logic [31:0]       cycle_cnt,
    output logic [31:0]       retired_cnt
`endif
);

    function automatic logic [CNT_W-1:0] burst_len(input logic [CNT_W-1:0] n);
        return (n == '0) ? CNT_W'(1) : n;
    endfunction

    exec_state_t       state, state_nxt;
    logic [CNT_W-1:0]  remaining, remaining_nxt;
    logic              skip_bp, skip_bp_nxt;
    logic              bp_hit_nxt;
    logic [IDX_W-1:0]  bp_hit_idx_nxt;

    logic              change_p, step_p;

    logic [ADDR_W-1:0] bp_addr_q [NUM_BP];
    logic [NUM_BP-1:0] bp_valid_q;
    logic [NUM_BP-1:0] slot_hit;
    logic [IDX_W-1:0]  hit_idx;
    logic              match;
    logic              bp_idx_ok;

    btn_edge_sync #(.STAGES(SYNC_STAGES)) u_change_sync (
        .clock (clock),
        .reset (reset),
        .btn   (change),
        .pulse (change_p)
    );

    btn_edge_sync #(.STAGES(SYNC_STAGES)) u_step_sync (
        .clock (clock),
        .reset (reset),
        .btn   (step),
        .pulse (step_p)
    );

    // Slot indices past NUM_BP exist only when NUM_BP is not a power of two.
    assign bp_idx_ok = ({1'b0, bp_idx} < (IDX_W+1)'(NUM_BP));

    always_ff @(posedge clock) begin
        if (reset) begin
            bp_valid_q <= '0;
        end else if (bp_we && bp_idx_ok) begin
            for (int i = 0; i < NUM_BP; i++) begin
                if (bp_idx == IDX_W'(i)) bp_valid_q[i] <= bp_valid;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (bp_we && bp_idx_ok) begin
            for (int i = 0; i < NUM_BP; i++) begin
                if (bp_idx == IDX_W'(i)) bp_addr_q[i] <= bp_addr;
            end
        end
    end

    for (genvar g = 0; g < NUM_BP; g++) begin : g_slot
        assign slot_hit[g] = bp_valid_q[g] && (bp_addr_q[g] == pc);
    end

    // Lowest-index slot wins.
    always_comb begin
        hit_idx = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (slot_hit[i]) hit_idx = IDX_W'(i);
        end
    end

    // skip_bp lets the instruction at a breakpoint run once after resuming.
    assign match   = (|slot_hit) && !skip_bp;
    assign core_en = !reset && (state == S_RUN || state == S_STEP) && !match && !halt_req;
    assign halted  = (state == S_HALT);
    assign mode    = state;

    always_comb begin
        state_nxt      = state;
        remaining_nxt  = remaining;
        skip_bp_nxt    = core_en ? 1'b0 : skip_bp;
        bp_hit_nxt     = bp_hit;
        bp_hit_idx_nxt = bp_hit_idx;
        unique case (state)
            S_RUN: begin
                if (change_p) begin
                    state_nxt = S_HALT;
                end else if (match || halt_req) begin
                    state_nxt = S_HALT;
                    if (match) begin
                        bp_hit_nxt     = 1'b1;
                        bp_hit_idx_nxt = hit_idx;
                    end
                end
            end
            S_HALT: begin
                if (change_p) begin
                    state_nxt   = S_RUN;
                    skip_bp_nxt = 1'b1;
                    bp_hit_nxt  = 1'b0;
                end else if (step_p) begin
                    state_nxt     = S_STEP;
                    remaining_nxt = burst_len(step_count);
                    skip_bp_nxt   = 1'b1;
                    bp_hit_nxt    = 1'b0;
                end
            end
            S_STEP: begin
                if (change_p) begin
                    state_nxt     = S_HALT;
                    remaining_nxt = '0;
                end else if (match || halt_req) begin
                    state_nxt     = S_HALT;
                    remaining_nxt = '0;
                    if (match) begin
                        bp_hit_nxt     = 1'b1;
                        bp_hit_idx_nxt = hit_idx;
                    end
                end else if (core_en) begin
                    remaining_nxt = remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) state_nxt = S_HALT;
                end
            end
            default: begin
                state_nxt = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_RUN;
            remaining  <= '0;
            skip_bp    <= 1'b0;
            bp_hit     <= 1'b0;
            bp_hit_idx <= '0;
        end else begin
            state      <= state_nxt;
            remaining  <= remaining_nxt;
            skip_bp    <= skip_bp_nxt;
            bp_hit     <= bp_hit_nxt;
            bp_hit_idx <= bp_hit_idx_nxt;
        end
    end

`ifdef MIPS_EXEC_CTRL_PERF_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_cnt   <= '0;
            retired_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (core_en) retired_cnt <= retired_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mips_exec_ctrl.sv
// tb_mips_exec_ctrl
//   Directed bench for mips_exec_ctrl with a cycle-level reference model and
//   hand-computed literal expectations.
module tb_mips_exec_ctrl;
    import mips_exec_ctrl_pkg::*;

    localparam int ADDR_W = 32;
    localparam int NUM_BP = 4;
    localparam int CNT_W  = 8;
    localparam int SS     = 2;
    localparam int IDX_W  = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              change = 1'b0;
    logic              step = 1'b0;
    logic [CNT_W-1:0]  step_count = '0;
    logic              halt_req = 1'b0;
    logic [ADDR_W-1:0] pc = '0;
    logic              bp_we = 1'b0;
    logic [IDX_W-1:0]  bp_idx = '0;
    logic [ADDR_W-1:0] bp_addr = '0;
    logic              bp_valid = 1'b0;
    logic              core_en, halted, bp_hit;
    logic [MODE_W-1:0] mode;
    logic [IDX_W-1:0]  bp_hit_idx;
`ifdef MIPS_EXEC_CTRL_PERF_EN
    logic [31:0]       cycle_cnt, retired_cnt;
`endif

    int   checks = 0;
    int   errors = 0;
    logic en_obs = 1'b0;
    bit   pc_auto = 1'b0;

    mips_exec_ctrl #(
        .ADDR_W(ADDR_W), .NUM_BP(NUM_BP), .CNT_W(CNT_W), .SYNC_STAGES(SS)
    ) dut (
        .clock(clock), .reset(reset), .change(change), .step(step),
        .step_count(step_count), .halt_req(halt_req), .pc(pc),
        .bp_we(bp_we), .bp_idx(bp_idx), .bp_addr(bp_addr), .bp_valid(bp_valid),
        .core_en(core_en), .halted(halted), .mode(mode),
        .bp_hit(bp_hit), .bp_hit_idx(bp_hit_idx)
`ifdef MIPS_EXEC_CTRL_PERF_EN
        , .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // mode: 0 run, 1 halt, 2 step. Buttons kept as a history of sampled levels.
    int                m_mode = 0;
    int                m_left = 0;
    bit                m_skip = 1'b0;
    bit                m_hit = 1'b0;
    int                m_idx = 0;
    bit                m_val [NUM_BP];
    logic [ADDR_W-1:0] m_addr [NUM_BP];
    bit                hc [SS+2];
    bit                hs [SS+2];
    bit                m_live = 1'b0;
    longint unsigned   m_cyc = 0;
    longint unsigned   m_ret = 0;

    function automatic int m_first_hit();
        if (m_skip) return -1;
        for (int i = 0; i < NUM_BP; i++)
            if (m_val[i] && m_addr[i] == pc) return i;
        return -1;
    endfunction

    function automatic bit m_en();
        return !reset && m_mode != 1 && m_first_hit() < 0 && !halt_req;
    endfunction

    task automatic model_step();
        bit cp, sp, en;
        int h;
        if (reset) begin
            m_mode = 0; m_left = 0; m_skip = 0; m_hit = 0; m_idx = 0;
            m_cyc = 0; m_ret = 0;
            foreach (m_val[i]) m_val[i] = 1'b0;
            foreach (hc[i]) begin hc[i] = 1'b0; hs[i] = 1'b0; end
            m_live = 1'b1;
            return;
        end
        cp = hc[SS] && !hc[SS+1];
        sp = hs[SS] && !hs[SS+1];
        h  = m_first_hit();
        en = m_en();
        m_cyc++;
        if (en) begin m_ret++; m_skip = 1'b0; end
        case (m_mode)
            0: if (cp) m_mode = 1;
               else if (h >= 0 || halt_req) begin
                   m_mode = 1;
                   if (h >= 0) begin m_hit = 1'b1; m_idx = h; end
               end
            1: if (cp) begin m_mode = 0; m_skip = 1'b1; m_hit = 1'b0; end
               else if (sp) begin
                   m_mode = 2; m_left = (step_count == 0) ? 1 : int'(step_count);
                   m_skip = 1'b1; m_hit = 1'b0;
               end
            default: if (cp) begin m_mode = 1; m_left = 0; end
               else if (h >= 0 || halt_req) begin
                   m_mode = 1; m_left = 0;
                   if (h >= 0) begin m_hit = 1'b1; m_idx = h; end
               end else if (en) begin
                   m_left--;
                   if (m_left == 0) m_mode = 1;
               end
        endcase
        if (bp_we) begin m_addr[bp_idx] = bp_addr; m_val[bp_idx] = bp_valid; end
        for (int i = SS + 1; i > 0; i--) begin hc[i] = hc[i-1]; hs[i] = hs[i-1]; end
        hc[0] = change;
        hs[0] = step;
    endtask

    // Compare every cycle just before the active edge, then advance the model.
    initial begin
        forever begin
            @(negedge clock);
            #4;
            en_obs = core_en;
            if (m_live) begin
                chk("core_en", 64'(core_en), 64'(m_en()));
                chk("mode", 64'(mode), 64'(m_mode));
                chk("halted", 64'(halted), 64'(m_mode == 1));
                chk("bp_hit", 64'(bp_hit), 64'(m_hit));
                chk("bp_hit_idx", 64'(bp_hit_idx), 64'(m_idx));
`ifdef MIPS_EXEC_CTRL_PERF_EN
                chk("cycle_cnt", 64'(cycle_cnt), 64'(m_cyc[31:0]));
                chk("retired_cnt", 64'(retired_cnt), 64'(m_ret[31:0]));
`endif
            end
            @(posedge clock);
            model_step();
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(negedge clock);
        if (pc_auto && en_obs === 1'b1) pc = (pc + 32'd4) & 32'h1f;
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) cyc();
    endtask

    task automatic wait_halt(input string name);
        for (int i = 0; i < 60; i++) begin
            if (halted === 1'b1) break;
            cyc();
        end
        chk(name, 64'(halted), 64'd1);
    endtask

    initial begin
        int n;
        cycles(2);
        reset = 1'b0;
        #1;
        // 1: out of reset, free run
        chk("t1_core_en", 64'(core_en), 64'd1);
        chk("t1_mode", 64'(mode), 64'(S_RUN));
        chk("t1_bp_hit", 64'(bp_hit), 64'd0);
        cycles(3);
        chk("t1_core_en_later", 64'(core_en), 64'd1);

        // 2: change toggles halt after SS+2 cycles, then back to run
        change = 1'b1;
        cycles(SS + 1);
        chk("t2_not_yet_halted", 64'(halted), 64'd0);
        cyc();
        chk("t2_halted", 64'(halted), 64'd1);
        chk("t2_core_en_off", 64'(core_en), 64'd0);
        change = 1'b0;
        cycles(2);
        change = 1'b1;
        cycles(SS + 2);
        chk("t2_run_again", 64'(mode), 64'(S_RUN));
        change = 1'b0;
        cycles(2);
        change = 1'b1;
        cycles(SS + 2);
        change = 1'b0;
        chk("t2_halt_again", 64'(halted), 64'd1);
        cycles(2);

        // 3: step bursts of 3 and of 0 (=1)
        step_count = 8'd3;
        step = 1'b1;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            cyc();
            if (i == 2) step = 1'b0;
            n += int'(core_en);
        end
        chk("t3_burst3", 64'(n), 64'd3);
        chk("t3_halted", 64'(halted), 64'd1);
        step_count = 8'd0;
        step = 1'b1;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            cyc();
            if (i == 2) step = 1'b0;
            n += int'(core_en);
        end
        chk("t3_burst0", 64'(n), 64'd1);

        // 4: breakpoints at 0x10 in slots 2 and 3; slot 2 must win
        bp_we = 1'b1; bp_idx = 2'd2; bp_addr = 32'h10; bp_valid = 1'b1;
        cyc();
        bp_idx = 2'd3;
        cyc();
        bp_we = 1'b0;
        pc = 32'h0;
        pc_auto = 1'b1;
        change = 1'b1;
        cycles(SS + 2);
        change = 1'b0;
        chk("t4_running", 64'(mode), 64'(S_RUN));
        wait_halt("t4_wait_bp");
        chk("t4_pc", 64'(pc), 64'h10);
        chk("t4_core_en", 64'(core_en), 64'd0);
        chk("t4_bp_hit", 64'(bp_hit), 64'd1);
        chk("t4_bp_idx", 64'(bp_hit_idx), 64'd2);
        change = 1'b1;
        cycles(SS + 2);
        change = 1'b0;
        chk("t4_resume_pc", 64'(pc), 64'h10);
        chk("t4_resume_en", 64'(core_en), 64'd1);
        chk("t4_hit_cleared", 64'(bp_hit), 64'd0);
        cyc();
        chk("t4_past_bp", 64'(pc), 64'h14);
        wait_halt("t4_wait_rehit");
        chk("t4_rehit_pc", 64'(pc), 64'h10);
        chk("t4_rehit_flag", 64'(bp_hit), 64'd1);

        // 5: change and step together from halt: change wins
        step_count = 8'd5;
        change = 1'b1;
        step = 1'b1;
        cycles(SS + 2);
        change = 1'b0;
        step = 1'b0;
        chk("t5_mode_run", 64'(mode), 64'(S_RUN));
        wait_halt("t5_wait_rehit");

        // halt_req: halt exit allowed but no enable while it is high
        bp_we = 1'b1; bp_idx = 2'd2; bp_valid = 1'b0;
        cyc();
        bp_idx = 2'd3;
        cyc();
        bp_we = 1'b0;
        halt_req = 1'b1;
        change = 1'b1;
        cycles(SS + 2);
        change = 1'b0;
        chk("thr_exit_run", 64'(mode), 64'(S_RUN));
        chk("thr_core_en", 64'(core_en), 64'd0);
        cyc();
        chk("thr_rehalt", 64'(halted), 64'd1);
        chk("thr_no_bp_hit", 64'(bp_hit), 64'd0);
        halt_req = 1'b0;
        cycles(2);

        // 6: reset in the middle of a step burst
        pc_auto = 1'b0;
        pc = 32'h200;
        step_count = 8'd8;
        step = 1'b1;
        cycles(SS + 2);
        step = 1'b0;
        chk("t6_stepping", 64'(mode), 64'(S_STEP));
        cycles(3);
        chk("t6_still_stepping", 64'(mode), 64'(S_STEP));
        reset = 1'b1;
        #1;
        chk("t6_reset_no_en", 64'(core_en), 64'd0);
        cyc();
        reset = 1'b0;
        pc = 32'h10;
        #1;
        chk("t6_mode_run", 64'(mode), 64'(S_RUN));
        chk("t6_slots_cleared", 64'(core_en), 64'd1);
`ifdef MIPS_EXEC_CTRL_PERF_EN
        chk("t6_cycle_cnt", 64'(cycle_cnt), 64'd0);
        chk("t6_retired_cnt", 64'(retired_cnt), 64'd0);
`endif
        cycles(4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
